sfp_port_manager: RTL and testbench
===================================

SFP_PORT_MANAGER -- requirements
Module: sfp_port_manager

Interface
REQ-001 Parameter N_CH, default 4: number of SFP cages, 1..16.
REQ-002 Parameter DEB_CYCLES, default 255: consecutive stable cycles required for a debounced input change, 1..65535.
REQ-003 Parameter T_INIT, default 4096: cycles tx_dis is held high after module insertion, 1..65535.
REQ-004 Parameter T_RETRY, default 4096: cycles tx_dis is held high after a tx_fault before retry, 1..65535.
REQ-005 Parameter MAX_RETRY, default 3: faults tolerated before LOCKOUT, 1..15.
REQ-006 Clock and reset: one clock; reset is asynchronous and active-low.
REQ-007 clk  input  1  sole clock; all state on rising edge.
REQ-008 rst_n  input  1  asynchronous active-low reset.
REQ-009 mod_abs  input  N_CH  raw MOD_DEF0 per cage; 1 = absent; asynchronous.
REQ-010 rx_los  input  N_CH  raw RX_LOS per cage; asynchronous.
REQ-011 tx_fault  input  N_CH  raw TX_FAULT per cage; asynchronous.
REQ-012 ch_en  input  N_CH  software enable per cage, synchronous.
REQ-013 fault_clr  input  N_CH  single-cycle pulse per cage; clears sticky fault and LOCKOUT.
REQ-014 tx_dis  output  N_CH  registered TX_DISABLE per cage; 1 = laser off.
REQ-015 present  output  N_CH  debounced !mod_abs.
REQ-016 link_up  output  N_CH  1 when channel in ENABLED and debounced rx_los = 0.
REQ-017 fault_sticky  output  N_CH  set on any debounced tx_fault rising edge; held until fault_clr.
REQ-018 locked_out  output  N_CH  1 while channel in LOCKOUT.

Function
REQ-019 Each raw input passes a 2-flop synchronizer, then a per-bit debouncer; the debounced value updates only after the synchronized value differs from it for DEB_CYCLES consecutive cycles; any glitch restarts the count.
REQ-020 Latency raw edge -> debounced edge = 2 + DEB_CYCLES cycles; debounced -> output = 1 further cycle.
REQ-021 Per-channel FSM states: ABSENT, INIT, ENABLED, FAULT, LOCKOUT; all channels independent.
REQ-022 ABSENT: tx_dis=1; go INIT when present=1 and ch_en=1; retry counter cleared.
REQ-023 INIT: tx_dis=1; timer counts T_INIT cycles then go ENABLED.
REQ-024 ENABLED: tx_dis=0; debounced tx_fault=1 -> retry count +1; if new count >= MAX_RETRY go LOCKOUT else go FAULT.
REQ-025 FAULT: tx_dis=1; timer counts T_RETRY cycles then go INIT.
REQ-026 LOCKOUT: tx_dis=1; exit to ABSENT only on fault_clr; retry counter cleared on exit.
REQ-027 From any state, present=0 or ch_en=0 -> ABSENT next cycle; takes priority over all other transitions; fault_sticky preserved.
REQ-028 fault_clr coincident with a new fault rising edge: set wins, fault_sticky stays 1.
REQ-029 Retry counter saturates at MAX_RETRY; it clears after ENABLED is held continuously for T_RETRY cycles.
REQ-030 Timers are saturating, width ceil(log2(max(T_INIT,T_RETRY)+1)); reload on state entry.

Reset
REQ-031 On rst_n=0: all FSMs ABSENT; tx_dis all 1; present, link_up, fault_sticky, locked_out all 0; synchronizers and debounced values set to absent/idle (mod_abs=1, rx_los=1, tx_fault=0); counters 0.
REQ-032 Reset deassertion mid-operation restarts every channel from ABSENT; no output glitches low on tx_dis during or after reset.

Configuration
REQ-033 Macro SFP_PORT_MANAGER_IRQ_EN: when defined, adds output irq (1 bit, registered), pulsing 1 for one cycle on any change of present, link_up, or locked_out on any channel; reset value 0.
REQ-034 Without SFP_PORT_MANAGER_IRQ_EN, the irq port and its change-detect logic do not exist; all other behaviour is identical.

Verification (N_CH=2, DEB_CYCLES=4, T_INIT=8, T_RETRY=16, MAX_RETRY=2)
REQ-035 Insertion: ch0 mod_abs 1->0 with ch_en=1 -> present[0]=1 after 7 cycles, tx_dis[0] falls 8 cycles later; ch1 stays tx_dis=1.
REQ-036 Glitch: mod_abs[0] low for 3 cycles then high -> present[0] never rises.
REQ-037 Retry/lockout: in ENABLED, assert tx_fault[0] for 10 cycles twice -> first gives FAULT, 16 cycles, INIT, re-enable; second gives locked_out[0]=1, tx_dis[0]=1; fault_clr -> ABSENT then INIT.
REQ-038 Removal priority: mod_abs[0]=1 during FAULT -> ABSENT after debounce; fault_sticky[0] stays 1.
REQ-039 Async reset: rst_n low mid-ENABLED -> tx_dis=2'b11 immediately, all status 0; with IRQ_EN, link_up change pulses irq for one cycle.

Source files
------------

// File: rtl/sfp_port_manager.sv
// SFP cage supervisor: input synchronisation/debounce, per-cage power-up/retry/lockout FSM
// and registered status. Optional irq output enabled by `define SFP_PORT_MANAGER_IRQ_EN.
module sfp_port_manager #(
  parameter int N_CH       = 4,
  parameter int DEB_CYCLES = 255,
  parameter int T_INIT     = 4096,
  parameter int T_RETRY    = 4096,
  parameter int MAX_RETRY  = 3
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [N_CH-1:0] mod_abs,
  input  logic [N_CH-1:0] rx_los,
  input  logic [N_CH-1:0] tx_fault,
  input  logic [N_CH-1:0] ch_en,
  input  logic [N_CH-1:0] fault_clr,
  output logic [N_CH-1:0] tx_dis,
  output logic [N_CH-1:0] present,
  output logic [N_CH-1:0] link_up,
  output logic [N_CH-1:0] fault_sticky,
  output logic [N_CH-1:0] locked_out
`ifdef SFP_PORT_MANAGER_IRQ_EN
  ,
  output logic            irq
`endif
);

  localparam int NB   = 3 * N_CH;
  localparam int DW   = $clog2(DEB_CYCLES + 1);
  localparam int TMAX = (T_INIT > T_RETRY) ? T_INIT : T_RETRY;
  localparam int TW   = $clog2(TMAX + 1);

  localparam logic [DW-1:0] DEB_M1     = DW'(DEB_CYCLES - 1);
  localparam logic [TW-1:0] T_INIT_M1  = TW'(T_INIT - 1);
  localparam logic [TW-1:0] T_RETRY_M1 = TW'(T_RETRY - 1);
  localparam logic [TW-1:0] TMAX_V     = TW'(TMAX);
  localparam logic [4:0]    MAX_V      = 5'(MAX_RETRY);
  // Idle levels: tx_fault deasserted, rx_los asserted, module absent.
  localparam logic [NB-1:0] IDLE_VAL   = {{N_CH{1'b0}}, {N_CH{1'b1}}, {N_CH{1'b1}}};

  typedef enum logic [2:0] {ABSENT, INIT, ENABLED, FAULT, LOCKOUT} state_t;

  logic [NB-1:0]   raw;
  logic [NB-1:0]   sync1_reg;
  logic [NB-1:0]   sync2_reg;
  logic [NB-1:0]   deb_val;
  logic [N_CH-1:0] abs_deb;
  logic [N_CH-1:0] los_deb;
  logic [N_CH-1:0] flt_deb;

  logic [N_CH-1:0] tx_dis_reg, tx_dis_next;
  logic [N_CH-1:0] present_reg, present_next;
  logic [N_CH-1:0] link_up_reg, link_up_next;
  logic [N_CH-1:0] fault_sticky_reg, fault_sticky_next;
  logic [N_CH-1:0] locked_out_reg, locked_out_next;

  assign raw = {tx_fault, rx_los, mod_abs};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_reg <= IDLE_VAL;
      sync2_reg <= IDLE_VAL;
    end else begin
      sync1_reg <= raw;
      sync2_reg <= sync1_reg;
    end
  end

  // Debounced bit follows the synchronised bit only after DEB_CYCLES consecutive disagreements.
  for (genvar gi = 0; gi < NB; gi++) begin : g_deb
    logic [DW-1:0] cnt_reg;
    logic          deb_bit_reg;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        cnt_reg     <= '0;
        deb_bit_reg <= IDLE_VAL[gi];
      end else if (sync2_reg[gi] == deb_bit_reg) begin
        cnt_reg <= '0;
      end else if (cnt_reg == DEB_M1) begin
        cnt_reg     <= '0;
        deb_bit_reg <= sync2_reg[gi];
      end else begin
        cnt_reg <= cnt_reg + DW'(1);
      end
    end

    assign deb_val[gi] = deb_bit_reg;
  end

  assign abs_deb      = deb_val[N_CH-1:0];
  assign los_deb      = deb_val[2*N_CH-1:N_CH];
  assign flt_deb      = deb_val[3*N_CH-1:2*N_CH];
  assign present_next = ~abs_deb;

  for (genvar gi = 0; gi < N_CH; gi++) begin : g_ch
    state_t        state_reg, state_next;
    logic [TW-1:0] timer_reg, timer_next;
    logic [3:0]    retry_reg, retry_next;
    logic [4:0]    retry_inc;
    logic          flt_d_reg;
    logic          flt_rise;

    assign retry_inc = {1'b0, retry_reg} + 5'd1;
    assign flt_rise  = flt_deb[gi] & ~flt_d_reg;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        state_reg <= ABSENT;
        timer_reg <= '0;
        retry_reg <= '0;
        flt_d_reg <= 1'b0;
      end else begin
        state_reg <= state_next;
        timer_reg <= timer_next;
        retry_reg <= retry_next;
        flt_d_reg <= flt_deb[gi];
      end
    end

    always_comb begin
      state_next = state_reg;
      retry_next = retry_reg;
      timer_next = timer_reg;
      case (state_reg)
        ABSENT: begin
          retry_next = '0;
          if (!abs_deb[gi] && ch_en[gi]) state_next = INIT;
        end
        INIT: if (timer_reg == T_INIT_M1) state_next = ENABLED;
        ENABLED: begin
          if (flt_deb[gi]) begin
            if (retry_inc >= MAX_V) begin
              state_next = LOCKOUT;
              retry_next = MAX_V[3:0];
            end else begin
              state_next = FAULT;
              retry_next = retry_inc[3:0];
            end
          end else if (timer_reg >= T_RETRY_M1) begin
            // A long enough clean run forgives earlier faults.
            retry_next = '0;
          end
        end
        FAULT: if (timer_reg == T_RETRY_M1) state_next = INIT;
        LOCKOUT: begin
          if (fault_clr[gi]) begin
            state_next = ABSENT;
            retry_next = '0;
          end
        end
        default: state_next = ABSENT;
      endcase
      if (abs_deb[gi] || !ch_en[gi]) state_next = ABSENT;
      if (state_next != state_reg) timer_next = '0;
      else if (timer_reg != TMAX_V) timer_next = timer_reg + TW'(1);
    end

    assign tx_dis_next[gi]       = (state_next != ENABLED);
    assign link_up_next[gi]      = (state_next == ENABLED) && !los_deb[gi];
    assign locked_out_next[gi]   = (state_next == LOCKOUT);
    assign fault_sticky_next[gi] = flt_rise | (fault_sticky_reg[gi] & ~fault_clr[gi]);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_dis_reg       <= '1;
      present_reg      <= '0;
      link_up_reg      <= '0;
      fault_sticky_reg <= '0;
      locked_out_reg   <= '0;
    end else begin
      tx_dis_reg       <= tx_dis_next;
      present_reg      <= present_next;
      link_up_reg      <= link_up_next;
      fault_sticky_reg <= fault_sticky_next;
      locked_out_reg   <= locked_out_next;
    end
  end

  assign tx_dis       = tx_dis_reg;
  assign present      = present_reg;
  assign link_up      = link_up_reg;
  assign fault_sticky = fault_sticky_reg;
  assign locked_out   = locked_out_reg;

`ifdef SFP_PORT_MANAGER_IRQ_EN
  logic irq_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) irq_reg <= 1'b0;
    else irq_reg <= |((present_next ^ present_reg) | (link_up_next ^ link_up_reg) |
                      (locked_out_next ^ locked_out_reg));
  end

  assign irq = irq_reg;
`endif

endmodule

// File: tb/tb_sfp_port_manager.sv
// Scoreboard bench for sfp_port_manager: behavioural cage model predicts every cycle's
// outputs, a monitor compares them; directed latency/lockout/removal/reset checks on top.
module tb_sfp_port_manager;
  localparam int N = 2, DEB = 4, TI = 8, TR = 16, MR = 2;
  localparam int S_ABS = 0, S_INIT = 1, S_EN = 2, S_FLT = 3, S_LCK = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic [1:0] mod_abs = 2'b11, rx_los = 2'b10, tx_fault = 2'b00, ch_en = 2'b11, fault_clr = 2'b00;
  logic [1:0] tx_dis, present, link_up, fault_sticky, locked_out;

  sfp_port_manager #(.N_CH(N), .DEB_CYCLES(DEB), .T_INIT(TI), .T_RETRY(TR), .MAX_RETRY(MR)) dut (
    .clk(clk), .rst_n(rst_n), .mod_abs(mod_abs), .rx_los(rx_los), .tx_fault(tx_fault),
    .ch_en(ch_en), .fault_clr(fault_clr), .tx_dis(tx_dis), .present(present),
    .link_up(link_up), .fault_sticky(fault_sticky), .locked_out(locked_out)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [1:0] tx_dis, present, link_up, sticky, locked;
  } exp_t;
  exp_t q[$];

  int n_checks = 0;
  int n_fail = 0;

  // Reference model: bits 0-1 mod_abs, 2-3 rx_los, 4-5 tx_fault.
  bit [5:0]  s1_m, s2_m, deb_m;
  bit [31:0] hist_m[6];
  int        st_m[2], tin_m[2], retry_m[2];
  bit [1:0]  fprev_m, sticky_m;

  task automatic model_reset();
    bit [5:0] idle = 6'b00_11_11;
    s1_m = idle; s2_m = idle; deb_m = idle;
    for (int b = 0; b < 6; b++) hist_m[b] = idle[b] ? 32'hFFFF_FFFF : 32'h0;
    for (int c = 0; c < 2; c++) begin st_m[c] = S_ABS; tin_m[c] = 0; retry_m[c] = 0; end
    fprev_m = 0; sticky_m = 0;
  endtask

  task automatic model_edge();
    exp_t      e;
    bit [5:0]  deb_old;
    bit [31:0] mask = (32'd1 << DEB) - 1;
    int        nxt;
    bit        pres, los, flt;
    if (!rst_n) begin
      model_reset();
      e = '0; e.tx_dis = 2'b11;
      q.push_back(e);
      return;
    end
    deb_old = deb_m;
    for (int b = 0; b < 6; b++) begin
      hist_m[b] = {hist_m[b][30:0], s2_m[b]};
      // Flip once the last DEB synchronised samples all disagree with the held value.
      if ((hist_m[b] & mask) == (deb_m[b] ? 32'h0 : mask)) deb_m[b] = ~deb_m[b];
    end
    s2_m = s1_m;
    s1_m = {tx_fault, rx_los, mod_abs};
    for (int c = 0; c < 2; c++) begin
      pres = !deb_old[c]; los = deb_old[2+c]; flt = deb_old[4+c];
      if (flt && !fprev_m[c]) sticky_m[c] = 1'b1;
      else if (fault_clr[c]) sticky_m[c] = 1'b0;
      fprev_m[c] = flt;
      nxt = st_m[c];
      case (st_m[c])
        S_ABS:  if (pres && ch_en[c]) nxt = S_INIT;
        S_INIT: if (tin_m[c] + 1 == TI) nxt = S_EN;
        S_EN: begin
          if (flt) begin
            retry_m[c] = (retry_m[c] + 1 > MR) ? MR : retry_m[c] + 1;
            nxt = (retry_m[c] >= MR) ? S_LCK : S_FLT;
          end else if (tin_m[c] + 1 >= TR) retry_m[c] = 0;
        end
        S_FLT:  if (tin_m[c] + 1 == TR) nxt = S_INIT;
        S_LCK:  if (fault_clr[c]) nxt = S_ABS;
        default: nxt = S_ABS;
      endcase
      if (!pres || !ch_en[c]) nxt = S_ABS;
      if (nxt == S_ABS) retry_m[c] = 0;
      tin_m[c] = (nxt != st_m[c]) ? 0 : tin_m[c] + 1;
      st_m[c] = nxt;
      e.tx_dis[c]  = (st_m[c] != S_EN);
      e.present[c] = pres;
      e.link_up[c] = (st_m[c] == S_EN) && !los;
      e.sticky[c]  = sticky_m[c];
      e.locked[c]  = (st_m[c] == S_LCK);
    end
    q.push_back(e);
  endtask

  // Each step predicts the coming rising edge, then lets it happen.
  task automatic step(input int n);
    repeat (n) begin
      model_edge();
      @(negedge clk);
      fault_clr = 2'b00;
    end
  endtask

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endfunction

  function automatic bit sig(input int which, input int ch);
    case (which)
      0: return present[ch];
      1: return tx_dis[ch];
      2: return locked_out[ch];
      default: return link_up[ch];
    endcase
  endfunction

  task automatic wait_until(input string name, input int which, input int ch, input bit val,
                            input int limit, output int k);
    k = 0;
    while (sig(which, ch) != val && k < limit) begin step(1); k++; end
    if (sig(which, ch) != val) begin
      n_checks++; n_fail++;
      $display("FAIL %s: no change after %0d cycles, still %b, want %b", name, limit, sig(which, ch), val);
    end
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        n_checks++;
        if ({tx_dis, present, link_up, fault_sticky, locked_out} !== e) begin
          n_fail++;
          $display("FAIL scoreboard t=%0t got tx_dis=%b present=%b link_up=%b sticky=%b locked=%b want %b %b %b %b %b",
                   $time, tx_dis, present, link_up, fault_sticky, locked_out,
                   e.tx_dis, e.present, e.link_up, e.sticky, e.locked);
        end
      end
    end
  end

  initial begin : watchdog
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin : stimulus
    int k;
    bit seen;
    #1 rst_n = 1'b0;
    step(3);
    check("reset_tx_dis", tx_dis, 2'b11);
    check("reset_status", {present, link_up, fault_sticky, locked_out}, 0);
    rst_n = 1'b1;
    step(5);
    $display("[%0t] reset phase done", $time);

    mod_abs[0] = 1'b0;
    wait_until("insert_present", 0, 0, 1'b1, 30, k);
    check("insert_present_latency", k, 7);
    wait_until("insert_tx_en", 1, 0, 1'b0, 30, k);
    check("insert_tx_dis_latency", k, 8);
    check("insert_ch1_tx_dis", tx_dis[1], 1'b1);
    $display("[%0t] insertion phase done", $time);

    seen = 1'b0;
    mod_abs[1] = 1'b0;
    for (int i = 0; i < 3; i++) begin step(1); seen |= present[1]; end
    mod_abs[1] = 1'b1;
    for (int i = 0; i < 15; i++) begin step(1); seen |= present[1]; end
    check("glitch_present", seen, 1'b0);
    $display("[%0t] glitch phase done", $time);

    tx_fault[0] = 1'b1; step(10); tx_fault[0] = 1'b0;
    check("fault1_tx_dis", tx_dis[0], 1'b1);
    check("fault1_not_locked", locked_out[0], 1'b0);
    wait_until("fault1_reenable", 1, 0, 1'b0, 80, k);
    tx_fault[0] = 1'b1; step(10); tx_fault[0] = 1'b0;
    wait_until("fault2_lockout", 2, 0, 1'b1, 30, k);
    check("lockout_tx_dis", tx_dis[0], 1'b1);
    check("lockout_sticky", fault_sticky[0], 1'b1);
    step(20);
    check("lockout_held", locked_out[0], 1'b1);
    fault_clr[0] = 1'b1; step(1);
    check("clr_unlock", locked_out[0], 1'b0);
    check("clr_sticky", fault_sticky[0], 1'b0);
    wait_until("clr_reenable", 1, 0, 1'b0, 30, k);
    $display("[%0t] retry/lockout phase done", $time);

    tx_fault[0] = 1'b1; step(10); tx_fault[0] = 1'b0;
    mod_abs[0] = 1'b1;
    wait_until("remove_present", 0, 0, 1'b0, 20, k);
    step(2);
    check("remove_tx_dis", tx_dis[0], 1'b1);
    check("remove_sticky", fault_sticky[0], 1'b1);
    $display("[%0t] removal phase done", $time);

    mod_abs = 2'b00;
    for (int c = 0; c < 4000; c++) begin
      for (int ch = 0; ch < 2; ch++) begin
        if ($urandom_range(149) == 0) mod_abs[ch] = ~mod_abs[ch];
        if ($urandom_range(39) == 0) rx_los[ch] = ~rx_los[ch];
        if ($urandom_range(29) == 0) tx_fault[ch] = ~tx_fault[ch];
        if ($urandom_range(399) == 0) ch_en[ch] = ~ch_en[ch];
        fault_clr[ch] = ($urandom_range(79) == 0);
      end
      step(1);
    end
    $display("[%0t] random phase done", $time);

    mod_abs = 2'b00; rx_los = 2'b00; tx_fault = 2'b00; ch_en = 2'b11;
    step(10);
    fault_clr = 2'b11; step(1);
    wait_until("prep_ch0", 1, 0, 1'b0, 60, k);
    wait_until("prep_ch1", 1, 1, 1'b0, 60, k);
    step(2);
    check("prep_link_up", link_up, 2'b11);
    rst_n = 1'b0;
    #1;
    check("async_rst_tx_dis", tx_dis, 2'b11);
    check("async_rst_status", {present, link_up, fault_sticky, locked_out}, 0);
    step(3);
    rst_n = 1'b1;
    step(40);
    check("post_rst_link_up", link_up, 2'b11);
    $display("[%0t] async reset phase done", $time);

    repeat (3) @(posedge clk);
    #1;
    check("scoreboard_drain", q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
